// File: rtl/pe_col_drain.sv
// -----------------------------------------------------------------------------
// pe_col_drain
//   Column drain placed below the bottom PE row of the systolic array (one
//   instance per column). Partial sums from the last PE are accumulated over
//   NUM_PASSES weight-tile passes into a TILE_LEN-entry accumulator bank. On
//   the final pass each completed sum is pushed into a show-ahead output FIFO
//   that the result writer drains with a valid/ready handshake.
//
// Ports
//   clk, rst     clock; synchronous active-high reset
//   i_clr        single-cycle pulse: abort accumulation, flush FIFO, clear o_ovf
//   i_vld/i_data partial-sum stream from the bottom PE (no backpressure)
//   o_vld/o_data FIFO head (show-ahead); popped when o_vld && i_rdy
//   i_rdy        consumer ready
//   o_ovf        sticky: a final-pass result was dropped on a full FIFO
//   o_pass_idx   current pass number
//   o_busy       accumulation in progress or a sample sits in the input stage
// -----------------------------------------------------------------------------
module pe_col_drain #(
    parameter int IN_DATA_WIDTH = 24,
    parameter int ACC_WIDTH     = 32,
    parameter int TILE_LEN      = 8,
    parameter int NUM_PASSES    = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_vld,
    input  logic [IN_DATA_WIDTH-1:0] i_data,
    output logic                     o_vld,
    output logic [ACC_WIDTH-1:0]     o_data,
    input  logic                     i_rdy,
    output logic                     o_ovf,
    output logic [((NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1)-1:0] o_pass_idx,
    output logic                     o_busy
);

    localparam int EW = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [EW-1:0] ELEM_LAST = EW'(TILE_LEN - 1);
    localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

    // Accumulation wraps modulo 2^ACC_WIDTH; the partial sum is unsigned.
    function automatic logic [ACC_WIDTH-1:0] wrap_add(
        input logic [ACC_WIDTH-1:0]     base,
        input logic [IN_DATA_WIDTH-1:0] psum
    );
        return base + ACC_WIDTH'(psum);
    endfunction

    // Control state
    logic                 in_vld_p0_q;
    logic [EW-1:0]        elem_q, elem_d;
    logic [PW-1:0]        pass_q, pass_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_after_pop;
    logic [ACC_WIDTH-1:0] o_data_q, o_data_d;
    logic                 ovf_q;

    // Data state (not reset)
    logic [IN_DATA_WIDTH-1:0] in_data_p0_q;
    logic [ACC_WIDTH-1:0]     acc_q [TILE_LEN];
    logic [ACC_WIDTH-1:0]     mem_q [FIFO_DEPTH];

    logic                 accept_p1;
    logic                 last_pass;
    logic [ACC_WIDTH-1:0] acc_base_p1;
    logic [ACC_WIDTH-1:0] sum_p1;
    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 push_ok;
    logic                 drop;

    // ---- stage 1: accumulate the registered sample ----
    // i_clr discards the sample held in the input stage.
    assign accept_p1   = in_vld_p0_q && !i_clr;
    assign last_pass   = (pass_q == PASS_LAST);
    assign acc_base_p1 = (pass_q == '0) ? '0 : acc_q[elem_q];
    assign sum_p1      = wrap_add(acc_base_p1, in_data_p0_q);

    // FIFO handshake. A pop frees a slot for a push in the same cycle, so a
    // full FIFO only drops when nothing is leaving.
    assign push_req      = accept_p1 && last_pass;
    assign pop           = (cnt_q != '0) && i_rdy && !i_clr;
    assign full          = (cnt_q == FIFO_FULL);
    assign push_ok       = push_req && (!full || pop);
    assign drop          = push_req && full && !pop;
    assign cnt_after_pop = cnt_q - CW'(pop);
    assign cnt_d         = cnt_after_pop + CW'(push_ok);
    assign rd_ptr_d      = rd_ptr_q + AW'(pop);
    assign wr_ptr_d      = wr_ptr_q + AW'(push_ok);

    always_comb begin
        elem_d = elem_q;
        pass_d = pass_q;
        if (accept_p1) begin
            if (elem_q == ELEM_LAST) begin
                elem_d = '0;
                pass_d = last_pass ? '0 : pass_q + PW'(1);
            end else begin
                elem_d = elem_q + EW'(1);
            end
        end
    end

    // Registered head: if the incoming push lands in an otherwise empty FIFO
    // it becomes the head directly (the memory write is not yet visible);
    // otherwise the head is the oldest stored entry. When the FIFO drains the
    // last head value is held.
    always_comb begin
        o_data_d = o_data_q;
        if (push_ok && (cnt_after_pop == '0)) begin
            o_data_d = sum_p1;
        end else if (cnt_d != '0) begin
            o_data_d = mem_q[rd_ptr_d];
        end
    end

    // ---- stage 0 / stage 1 register boundary: control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            in_vld_p0_q <= 1'b0;
            elem_q      <= '0;
            pass_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            o_data_q    <= '0;
        end else if (i_clr) begin
            in_vld_p0_q <= 1'b0;
            elem_q      <= '0;
            pass_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            in_vld_p0_q <= i_vld;
            elem_q      <= elem_d;
            pass_q      <= pass_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            o_data_q    <= o_data_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ---- stage 0 / stage 1 register boundary: datapath ----
    // Only intermediate passes need the bank; pass 0 overwrites stale entries.
    always_ff @(posedge clk) begin
        in_data_p0_q <= i_data;
        if (accept_p1 && !last_pass) begin
            acc_q[elem_q] <= sum_p1;
        end
        if (push_ok) begin
            mem_q[wr_ptr_q] <= sum_p1;
        end
    end

    assign o_vld      = (cnt_q != '0);
    assign o_data     = o_data_q;
    assign o_ovf      = ovf_q;
    assign o_pass_idx = pass_q;
    assign o_busy     = (elem_q != '0) || (pass_q != '0) || in_vld_p0_q;

endmodule

// File: tb/tb_pe_col_drain.sv
module tb_pe_col_drain;

    localparam int T     = 4;
    localparam int P     = 2;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_clr = 1'b0;
    logic        i_vld = 1'b0;
    logic [23:0] i_data = '0;
    logic        o_vld;
    logic [23:0] o_data;
    logic        i_rdy = 1'b0;
    logic        o_ovf;
    logic [0:0]  o_pass_idx;
    logic        o_busy;

    pe_col_drain #(
        .IN_DATA_WIDTH(24),
        .ACC_WIDTH    (24),
        .TILE_LEN     (T),
        .NUM_PASSES   (P),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (i_clr),
        .i_vld     (i_vld),
        .i_data    (i_data),
        .o_vld     (o_vld),
        .o_data    (o_data),
        .i_rdy     (i_rdy),
        .o_ovf     (o_ovf),
        .o_pass_idx(o_pass_idx),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: sample counter k numbers accepted samples within one
    // result cycle; element and pass follow from plain division.
    int          m_k;
    logic        m_pv;
    logic [23:0] m_pd;
    logic [23:0] m_acc [T];
    logic [23:0] m_q [$];
    logic        m_ovf;
    logic [23:0] m_head;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [23:0] d, input logic r,
                              input logic c, input logic rs);
        int          e;
        int          p;
        logic [23:0] s;
        if (rs) begin
            m_k = 0; m_pv = 1'b0; m_q.delete(); m_ovf = 1'b0; m_head = '0;
        end else if (c) begin
            m_k = 0; m_pv = 1'b0; m_q.delete(); m_ovf = 1'b0;
        end else begin
            if (m_q.size() > 0 && r) void'(m_q.pop_front());
            if (m_pv) begin
                e = m_k % T;
                p = (m_k / T) % P;
                s = ((p == 0) ? 24'd0 : m_acc[e]) + m_pd;
                if (p < P - 1) m_acc[e] = s;
                else if (m_q.size() < DEPTH) m_q.push_back(s);
                else m_ovf = 1'b1;
                m_k = (m_k + 1) % (T * P);
            end
            m_pv = v;
            m_pd = d;
        end
        if (m_q.size() > 0) m_head = m_q[0];
    endtask

    task automatic step(input logic v, input logic [23:0] d, input logic r,
                        input logic c, input logic rs);
        i_vld = v; i_data = d; i_rdy = r; i_clr = c; rst = rs;
        @(posedge clk);
        model_edge(v, d, r, c, rs);
        #1;
        chk("o_vld", o_vld, m_q.size() > 0);
        chk("o_data", o_data, m_head);
        chk("o_ovf", o_ovf, m_ovf);
        chk("o_pass_idx", o_pass_idx, (m_k / T) % P);
        chk("o_busy", o_busy, (m_k != 0) || m_pv);
    endtask

    initial begin
        // Reset state
        step(0, 0, 0, 0, 1);
        chk("rst_vld", o_vld, 0);
        chk("rst_data", o_data, 0);
        chk("rst_busy", o_busy, 0);
        step(0, 0, 0, 0, 0);

        // Basic accumulation: 1..4 then 10..40 -> 11,22,33,44
        for (int i = 0; i < 4; i++) step(1, 24'(i + 1), 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 24'((i + 1) * 10), 1, 0, 0);
            if (i > 0) begin
                chk("basic_vld", o_vld, 1);
                chk("basic_data", o_data, 11 * i);
            end
        end
        step(0, 0, 1, 0, 0);
        chk("basic_data4", o_data, 44);
        step(0, 0, 1, 0, 0);
        chk("basic_empty", o_vld, 0);
        chk("basic_ovf", o_ovf, 0);

        // Wrap arithmetic on element 0
        step(0, 0, 0, 1, 0);
        step(1, 24'hFFFFFF, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 24'h000002, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("wrap_data", o_data, 24'h000001);

        // Overflow with consumer stalled
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 24'(5 + i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 24'(100 * (i + 1)), 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_head", o_data, 105);
        step(0, 0, 1, 0, 0);
        chk("ovf_head2", o_data, 206);
        step(0, 0, 1, 0, 0);
        chk("ovf_empty", o_vld, 0);
        chk("ovf_hold_data", o_data, 206);
        step(0, 0, 1, 0, 0);
        chk("ovf_sticky", o_ovf, 1);
        step(0, 0, 0, 1, 0);
        chk("ovf_clr", o_ovf, 0);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) step(1, 24'(i + 1), 0, 0, 0);
        step(1, 1000, 0, 0, 0);
        step(1, 2000, 0, 0, 0);
        step(1, 3000, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("pp_head", o_data, 2002);
        step(0, 0, 1, 0, 0);
        chk("pp_head2", o_data, 3003);
        step(0, 0, 1, 0, 0);
        chk("pp_empty", o_vld, 0);
        chk("pp_ovf", o_ovf, 0);

        // Clear mid-pass with a sample arriving
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 24'(7 + i), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("clr_busy_before", o_busy, 1);
        step(1, 55, 1, 1, 0);
        chk("clr_busy", o_busy, 0);
        for (int i = 0; i < 4; i++) step(1, 24'(i + 3), 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 24'(i * 7), 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("clr_fresh_sum", o_data, 6 + 21);
        step(0, 0, 1, 0, 0);

        // Reset with FIFO holding two entries during pass 1
        for (int i = 0; i < 4; i++) step(1, 24'(i + 1), 0, 0, 0);
        step(1, 50, 0, 0, 0);
        step(1, 60, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("pre_rst_pass", o_pass_idx, 1);
        chk("pre_rst_vld", o_vld, 1);
        step(0, 0, 0, 0, 1);
        chk("rst2_vld", o_vld, 0);
        chk("rst2_pass", o_pass_idx, 0);
        chk("rst2_ovf", o_ovf, 0);
        chk("rst2_busy", o_busy, 0);
        chk("rst2_data", o_data, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic        v;
            logic [23:0] d;
            v = ($urandom_range(0, 9) < 7);
            d = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            step(v, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pe_col_drain.md
Name: pe_col_drain

Overview:
- Sits directly below the bottom PE row of the systolic array, one instance per column.
- Consumes the column's partial-sum stream (o_down_data qualified by o_pop_vld of the last PE) and accumulates it across NUM_PASSES weight-tile passes into a TILE_LEN-entry accumulator bank.
- On the final pass, pushes completed sums into a show-ahead output FIFO drained with a valid/ready handshake toward the result writer.

Parameters:
- IN_DATA_WIDTH, 24, width of incoming partial sum (unsigned)
- ACC_WIDTH, 32, accumulator and output width; must be >= IN_DATA_WIDTH
- TILE_LEN, 8, partial sums per pass (accumulator entries); >= 1
- NUM_PASSES, 4, passes accumulated per result; >= 1
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_clr  in  1  single-cycle pulse: abort current accumulation, zero counters, flush FIFO, clear o_ovf
- i_vld  in  1  partial sum valid (driven by bottom PE o_pop_vld)
- i_data  in  IN_DATA_WIDTH  partial sum (bottom PE o_down_data)
- o_vld  out  1  result available at FIFO head
- o_data  out  ACC_WIDTH  FIFO head result
- i_rdy  in  1  consumer accepts o_data when o_vld && i_rdy
- o_ovf  out  1  sticky: a final-pass result was dropped because the FIFO was full
- o_pass_idx  out  clog2(NUM_PASSES) or 1 bit if NUM_PASSES=1  current pass number
- o_busy  out  1  high while elem_idx != 0 or pass_idx != 0, or the input stage holds a valid sample

Behaviour:
- Reset (rst=1 at clock edge) values: o_vld=0, o_data=0, o_ovf=0, o_pass_idx=0, o_busy=0.
- Reset also empties the FIFO, zeroes elem_idx/pass_idx and clears the input stage. Accumulator contents are don't-care; pass 0 overwrites them.
- Stage 0, edge N: register i_vld/i_data into in_vld_r/in_data_r.
- Stage 1, edge N+1, if in_vld_r: compute sum = (pass_idx==0 ? 0 : acc[elem_idx]) + zero_extend(in_data_r).
  - Add wraps modulo 2^ACC_WIDTH; no saturation.
  - If pass_idx < NUM_PASSES-1: write sum to acc[elem_idx].
  - Else: push sum into the FIFO; the acc write is optional.
- Counters, advanced on each stage-1 accept:
  - elem_idx increments and wraps TILE_LEN-1 -> 0.
  - On that wrap, pass_idx increments and wraps NUM_PASSES-1 -> 0.
- NUM_PASSES=1: every sample goes straight to the FIFO as zero_extend(i_data).
- Latency: i_vld sampled at edge N; result visible on o_vld/o_data after edge N+1 if the FIFO was empty. This holds even when i_rdy is held high.
- No input backpressure: the upstream array cannot stall, so a sample is accepted every cycle i_vld=1.
- FIFO:
  - Show-ahead: o_data = head entry whenever o_vld=1, and o_data is stable while o_vld && !i_rdy.
  - Pop when o_vld && i_rdy.
  - Push and pop in the same cycle are both honoured; count is unchanged. This is allowed when full: a pop that cycle frees the slot and the push is accepted.
  - Push while full without a pop: the result is dropped, o_ovf=1 from the next cycle (sticky), and counters still advance.
  - o_data retains the last value when empty; do not clear it on pop.
- i_clr:
  - Same-edge effect as rst on counters, FIFO, in_vld_r and o_ovf.
  - Takes priority over a simultaneous i_vld or stage-1 accept; that sample is discarded.
  - A pop in the i_clr cycle is ignored.
- Reset mid-pass: partial accumulation is lost; the next sample after release is element 0 of pass 0.
- All outputs are registered or decoded from registers; no combinational path from i_vld/i_data to any output.
- o_ready-style input handshake is not provided.

Test Plan:
- Basic accumulation: TILE_LEN=4, NUM_PASSES=2, i_rdy=1. Pass 0 data 1,2,3,4, then pass 1 data 10,20,30,40, back-to-back -> o_vld pulses 4 cycles with o_data 11,22,33,44. Each result is 2 edges after its pass-1 sample. o_ovf=0.
- Wrap arithmetic: ACC_WIDTH=24=IN_DATA_WIDTH, NUM_PASSES=2, element 0 fed 0xFFFFFF then 0x000002 -> o_data=0x000001.
- Backpressure/overflow: FIFO_DEPTH=2, i_rdy=0, produce 3 final results A,B,C -> o_ovf=1 after C and the FIFO holds A,B. With i_rdy=1, A then B pop, then o_vld=0. o_ovf stays 1 until i_clr.
- Simultaneous push/pop at full: FIFO_DEPTH=2 full (A,B), i_rdy=1 in the same cycle result C arrives -> A pops, C accepted, then B, C drain. o_ovf=0.
- i_clr mid-pass: after pass 0 element 2 (pass_idx=0, elem_idx=3), pulse i_clr with i_vld=1 -> that sample discarded, o_busy=0. A fresh 2-pass sequence yields correct sums.
- Reset behaviour: assert rst with FIFO holding 2 entries and pass_idx=1 -> next cycle o_vld=0, o_pass_idx=0, o_ovf=0, o_busy=0, o_data=0.
